// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and default frame/oversample sizes.
// Used by the transmitter, the receiver and the baud generator.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts oversample ticks and flags the tick that closes a bit period.
// bit_end is combinational from the current count; the counter wraps on that same tick.
module uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic baud_tick,
   output logic bit_end
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] tick_cnt;

   assign bit_end = en && baud_tick && (tick_cnt == LAST_TICK);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         tick_cnt <= '0;
      end else if (en && baud_tick) begin
         tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops the TX FIFO and serialises start, LSB-first data, optional parity, stop bit(s).
// Line drops 3 edges after the empty flag is seen in IDLE; waits on an empty FIFO or tx_en low, never aborts a frame.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  baud_tick,
   input  logic                  tx_en,
   input  logic                  parity_en,
   input  logic                  parity_odd,
   input  logic                  stop2,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int BW = $clog2(DATA_WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   uart_tx_state_e        state, state_nxt;
   logic [DATA_WIDTH-1:0] shift, shift_nxt;
   logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
   logic                  par_en_q, par_en_nxt;
   logic                  par_bit_q, par_bit_nxt;
   logic                  stop2_q, stop2_nxt;
   logic                  tx_q, tx_nxt;
   logic                  done_q, done_nxt;
   logic                  tmr_clr, tmr_en, bit_end;

   // Timer runs only while a bit is on the line, so ticks in IDLE/FETCH/LOAD are ignored.
   assign tmr_clr = (state == LOAD);
   assign tmr_en  = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

   uart_bit_timer #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_bit_timer (
      .clk       (clk),
      .rst       (rst),
      .clr       (tmr_clr),
      .en        (tmr_en),
      .baud_tick (baud_tick),
      .bit_end   (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift     <= '0;
         bit_cnt   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         shift     <= shift_nxt;
         bit_cnt   <= bit_cnt_nxt;
         par_en_q  <= par_en_nxt;
         par_bit_q <= par_bit_nxt;
         stop2_q   <= stop2_nxt;
         tx_q      <= tx_nxt;
         done_q    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      shift_nxt   = shift;
      bit_cnt_nxt = bit_cnt;
      par_en_nxt  = par_en_q;
      par_bit_nxt = par_bit_q;
      stop2_nxt   = stop2_q;
      done_nxt    = 1'b0;
      tx_nxt      = 1'b1;

      case (state)
         IDLE: begin
            if (tx_en && !fifo_empty) state_nxt = FETCH;
         end
         FETCH: begin
            state_nxt = LOAD;
         end
         LOAD: begin
            shift_nxt   = fifo_data;
            par_en_nxt  = parity_en;
            par_bit_nxt = (^fifo_data) ^ parity_odd;
            stop2_nxt   = stop2;
            bit_cnt_nxt = '0;
            state_nxt   = START;
         end
         START: begin
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_nxt = shift >> 1;
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            // bit_cnt marks the first of two stop bits when stop2 was latched.
            if (bit_end) begin
               if (stop2_q && (bit_cnt == '0)) begin
                  bit_cnt_nxt = BW'(1);
               end else begin
                  bit_cnt_nxt = '0;
                  done_nxt    = 1'b1;
                  state_nxt   = (tx_en && !fifo_empty) ? FETCH : IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Line level follows the state being entered so tx moves on the same edge as the FSM.
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_nxt[0];
         PARITY:  tx_nxt = par_bit_nxt;
         default: tx_nxt = 1'b1;
      endcase
   end

   assign fifo_rd_en = (state == FETCH);
   assign busy       = (state != IDLE);
   assign tx         = tx_q;
   assign tx_done    = done_q;

endmodule
